alu_pipe: RTL and testbench

Parametrised, handshaked successor to the CCU's combinational 8-bit ALU. It accepts one operation per valid/ready transfer and returns a registered result with condition codes. It adds iterative unsigned multiply and divide, overflow and error flags, and backpressure on the result side. It sits between the CCU operand buses and the register-file write port; `out_valid && out_ready` is the write strobe.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_if.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 93 +++++++++
 rtl/alu_pipe.sv | 153 +++++++++++++++
 tb/tb_alu_pipe.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU pipeline.
//   - opcode encodings carried on the 4-bit n bus
//   - bit positions inside the 4-bit condition-code word
//   - handshake FSM state encoding (also exported on the debug port)
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_PASSA = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_MAX   = 4'd6;
  localparam logic [3:0] OP_MIN   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;

  localparam int CC_ARITH = 0;
  localparam int CC_ZERO  = 1;
  localparam int CC_SELA  = 2;
  localparam int CC_SELB  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MUL always iterates; DIV iterates only for a nonzero divisor.
  function automatic logic is_iterative(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bus between the CCU operand buses and the register-file
// write port.
//   master : operation producer (drives in_valid/a/b/n, out_ready)
//   slave  : the ALU (drives in_ready, out_valid/r/cc/ovf/err)
//
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both high; a result transfers on a rising edge where
// out_valid and out_ready are both high. Once out_valid is high, r/cc/ovf/err
// stay stable until that transfer. valid never depends on ready.
interface alu_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [3:0]       cc;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, a, b, n, out_ready,
    input  in_ready, out_valid, r, cc, ovf, err
  );

  modport slave (
    input  in_valid, a, b, n, out_ready,
    output in_ready, out_valid, r, cc, ovf, err
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : latch operands and begin WIDTH iterations
//   is_div      : 1 = divide a/b, 0 = multiply a*b (sampled with start)
//   a, b        : operands (sampled with start)
//   done        : high during the cycle whose edge performs the last iteration
//   result      : low product half or quotient, valid while done is high
//   hi_nonzero  : upper product half nonzero (multiply only), valid with done
// result/hi_nonzero look at the post-iteration accumulator so the caller can
// register them on the same edge that finishes the operation.
module alu_muldiv_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH:0]     sum, trial, diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    done     = 1'b0;
    sum      = '0;
    trial    = '0;
    diff     = '0;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      is_div_d = is_div;
      opnd_d   = is_div ? b : a;
      // Divide: {remainder, dividend}. Multiply: {partial sum, multiplier}.
      acc_d    = {{WIDTH{1'b0}}, (is_div ? a : b)};
    end else if (busy_q) begin
      if (is_div_q) begin
        // Remainder stays below the divisor, so the shifted trial needs one
        // extra bit; diff[WIDTH] is the borrow of the trial subtraction.
        trial = acc_q[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, opnd_q};
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        // Add multiplicand when the current multiplier LSB is set, then shift
        // the carry, partial sum and remaining multiplier right together.
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  assign result     = acc_d[WIDTH-1:0];
  assign hi_nonzero = !is_div_q && (|acc_d[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: one operation per in_valid/in_ready transfer, registered
// result with condition codes, held until out_ready.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_if slave (operands/opcode in, result/cc/ovf/err out)
//   dbg_state  : current handshake FSM state
// Single-cycle ops register their result on the accept edge; MUL and nonzero
// DIV run WIDTH iterations in alu_muldiv_iter first.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus,
  output state_t dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [3:0]       cc_q, cc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             in_ready, accept, multi;
  logic             m_done, m_hi;
  logic [WIDTH-1:0] m_res;
  logic [WIDTH-1:0] sc_r, add_r, sub_r;
  logic [3:0]       sc_cc;
  logic             sc_ovf, sc_err;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign multi    = is_iterative(bus.n, bus.b == '0);

  alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .start      (accept && multi),
    .is_div     (bus.n == OP_DIV),
    .a          (bus.a),
    .b          (bus.b),
    .done       (m_done),
    .result     (m_res),
    .hi_nonzero (m_hi)
  );

  // Single-cycle datapath, evaluated on the live operands at accept.
  always_comb begin
    add_r  = bus.a + bus.b;
    sub_r  = bus.a - bus.b;
    sc_r   = '0;
    sc_cc  = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    case (bus.n)
      OP_ADD: begin
        sc_r = add_r; sc_cc[CC_ARITH] = 1'b1;
        sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_r = sub_r; sc_cc[CC_ARITH] = 1'b1;
        sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL: begin
        sc_cc[CC_ARITH] = 1'b1;  // handled by the iterator
      end
      OP_DIV: begin
        // Only the divide-by-zero case completes here.
        sc_r = '1; sc_cc[CC_ARITH] = 1'b1; sc_err = 1'b1;
      end
      OP_PASSA: sc_r = bus.a;
      OP_PASSB: sc_r = bus.b;
      OP_MAX: begin
        if ($signed(bus.a) >= $signed(bus.b)) begin sc_r = bus.a; sc_cc[CC_SELA] = 1'b1; end
        else begin sc_r = bus.b; sc_cc[CC_SELB] = 1'b1; end
      end
      OP_MIN: begin
        if ($signed(bus.a) <= $signed(bus.b)) begin sc_r = bus.a; sc_cc[CC_SELA] = 1'b1; end
        else begin sc_r = bus.b; sc_cc[CC_SELB] = 1'b1; end
      end
      OP_SHL: begin sc_r = {bus.a[WIDTH-2:0], 1'b0}; sc_cc[CC_ARITH] = 1'b1; end
      OP_SHR: begin sc_r = {1'b0, bus.a[WIDTH-1:1]}; sc_cc[CC_ARITH] = 1'b1; end
      default: sc_err = 1'b1;
    endcase
    sc_cc[CC_ZERO] = sc_cc[CC_ARITH] && (sc_r == '0);
  end

  // State register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      cc_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cc_q    <= cc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = multi ? ST_BUSY : ST_DONE;
      ST_BUSY: if (m_done) state_d = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          if (accept) state_d = multi ? ST_BUSY : ST_DONE;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and result-register loads.
  always_comb begin
    r_d   = r_q;
    cc_d  = cc_q;
    ovf_d = ovf_q;
    err_d = err_q;
    if (accept && !multi) begin
      r_d   = sc_r;
      cc_d  = sc_cc;
      ovf_d = sc_ovf;
      err_d = sc_err;
    end else if ((state_q == ST_BUSY) && m_done) begin
      r_d            = m_res;
      cc_d           = '0;
      cc_d[CC_ARITH] = 1'b1;
      cc_d[CC_ZERO]  = (m_res == '0);
      ovf_d          = m_hi;
      err_d          = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.r         = r_q;
  assign bus.cc        = cc_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe (WIDTH=8).
module tb_alu_pipe;
  import alu_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;
  logic [13:0] exp_q[$];   // {r, cc, ovf, err}

  alu_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model computed from the arithmetic definition of each opcode.
  function automatic logic [13:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, s, u;
    logic [7:0] r;
    logic [3:0] cc;
    logic ovf, err;
    sa = $signed(a); sb = $signed(b);
    r = 8'h00; cc = 4'b0000; ovf = 1'b0; err = 1'b0;
    case (op)
      4'd0: begin u = a + b; r = u[7:0]; s = sa + sb; ovf = (s > 127) || (s < -128); cc[0] = 1'b1; end
      4'd1: begin u = a - b; r = u[7:0]; s = sa - sb; ovf = (s > 127) || (s < -128); cc[0] = 1'b1; end
      4'd2: begin u = a * b; r = u[7:0]; ovf = (u > 255); cc[0] = 1'b1; end
      4'd3: begin
        cc[0] = 1'b1;
        if (b == 0) begin r = 8'hFF; err = 1'b1; end
        else begin u = a / b; r = u[7:0]; end
      end
      4'd4: r = a;
      4'd5: r = b;
      4'd6: if (sa >= sb) begin r = a; cc[2] = 1'b1; end else begin r = b; cc[3] = 1'b1; end
      4'd7: if (sa <= sb) begin r = a; cc[2] = 1'b1; end else begin r = b; cc[3] = 1'b1; end
      4'd8: begin u = a * 2; r = u[7:0]; cc[0] = 1'b1; end
      4'd9: begin u = a / 2; r = u[7:0]; cc[0] = 1'b1; end
      default: err = 1'b1;
    endcase
    if (cc[0] && r == 8'h00) cc[1] = 1'b1;
    return {r, cc, ovf, err};
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [7:0] b);
    if (op == 4'd2 || (op == 4'd3 && b != 0)) return 9;
    return 1;
  endfunction

  // Drive one op from idle/done, check latency and result, optionally hold
  // out_ready low for 'hold' cycles afterwards and check the result is held.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold);
    int g, lat;
    logic [13:0] exp;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.a = a; bus.b = b; bus.n = op; bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 20) begin @(negedge clk); g++; end
    check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.n = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 32'(lat), 32'(model_latency(op, b)));
    exp = exp_q.pop_front();
    check({tag, "_res"}, 32'({bus.r, bus.cc, bus.ovf, bus.err}), 32'(exp));
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        check({tag, "_hold"}, 32'({bus.out_valid, bus.r, bus.cc, bus.ovf, bus.err}), 32'({1'b1, exp}));
      end
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int k);
    bus.in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] ra, rb;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'({bus.out_valid, bus.r, bus.cc, bus.ovf, bus.err}), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Directed operations
    run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 0);
    check("add_r_const", 32'({bus.r, bus.cc, bus.ovf}), 32'({8'h80, 4'b0001, 1'b1}));
    run_op("sub_eq", OP_SUB, 8'h05, 8'h05, 0);
    check("sub_cc_const", 32'({bus.r, bus.cc}), 32'({8'h00, 4'b0011}));
    run_op("max_neg", OP_MAX, 8'hFF, 8'h01, 0);
    check("max_cc_const", 32'({bus.r, bus.cc}), 32'({8'h01, 4'b1000}));
    run_op("min_tie", OP_MIN, 8'h03, 8'h03, 0);
    check("min_cc_const", 32'({bus.r, bus.cc}), 32'({8'h03, 4'b0100}));
    run_op("mul_ovf", OP_MUL, 8'h10, 8'h20, 0);
    check("mul_ovf_const", 32'({bus.r, bus.cc, bus.ovf}), 32'({8'h00, 4'b0011, 1'b1}));
    run_op("mul_small", OP_MUL, 8'h0F, 8'h03, 0);
    run_op("div", OP_DIV, 8'hC8, 8'h07, 0);
    check("div_const", 32'(bus.r), 32'h1C);
    run_op("div_zero", OP_DIV, 8'h42, 8'h00, 0);
    run_op("illegal12", 4'd12, 8'h33, 8'h44, 0);
    run_op("shl", OP_SHL, 8'h81, 8'h00, 0);
    run_op("shr", OP_SHR, 8'h81, 8'h00, 0);
    run_op("sub_ovf", OP_SUB, 8'h80, 8'h01, 0);

    // Backpressure and same-edge accept on release
    idle_cycles(2);
    @(negedge clk);
    bus.out_ready = 1'b0; bus.a = 8'h00; bus.b = 8'hA5; bus.n = OP_PASSB; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_first", 32'({bus.out_valid, bus.r, bus.cc}), 32'({1'b1, 8'hA5, 4'b0000}));
    bus.a = 8'h03; bus.b = 8'h04; bus.n = OP_ADD;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold", 32'({bus.out_valid, bus.in_ready, bus.r}), 32'({1'b1, 1'b0, 8'hA5}));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_b2b", 32'({bus.out_valid, bus.r, bus.cc, bus.ovf, bus.err}),
          32'({1'b1, model(OP_ADD, 8'h03, 8'h04)}));

    // Reset during BUSY aborts the multiply
    idle_cycles(2);
    @(negedge clk);
    bus.a = 8'h0F; bus.b = 8'h0F; bus.n = OP_MUL; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'({bus.out_valid, bus.in_ready, bus.r, bus.cc, bus.ovf, bus.err}),
          32'({1'b0, 1'b1, 14'd0}));
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      check("rst_no_result", 32'(bus.out_valid), 32'd0);
    end
    run_op("add_after_rst", OP_ADD, 8'h12, 8'h34, 0);

    // Randomized operations with occasional backpressure
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(10, 15));
      else                           op = 4'($urandom_range(0, 9));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, $urandom_range(0, 2));
    end

    idle_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
